// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment order everywhere is {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package sseg_pkg;

    // Widest display the driver supports; the anode helper works at this width
    localparam int MAX_DIGITS = 8;

    // All segments dark
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs 0..F, active-low
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Builds the anode vector for one selected digit. With enable low every
    // anode is inactive, which is how the anti-ghost blanking window is made.
    // The result is always MAX_DIGITS wide; callers keep the low N_DIGITS bits.
    function automatic logic [MAX_DIGITS-1:0] anode_vector(
        input logic [2:0] idx,
        input logic       enable,
        input logic       active_low
    );
        logic [MAX_DIGITS-1:0] onehot;
        onehot = '0;
        if (enable) begin
            onehot[idx] = 1'b1;
        end
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/sseg_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module sseg_hex_glyph
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Plain table lookup; every nibble value has a glyph
    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver.
// Keeps a committed copy of the digit data, walks one digit per refresh slot,
// blanks the start of each slot to stop ghosting, and drives shared active-low
// segments plus one anode per digit. Loads can be deferred to the frame wrap
// so a whole frame is always drawn from one consistent data set.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int  N_DIGITS      = 4,
    parameter int  REFRESH_DIV   = 50000,
    parameter int  BLANK_CYC     = 16,
    parameter int  AN_ACTIVE_LOW = 1,
    parameter int  FRAME_SYNC    = 1,
    localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lzs_en,
    input  logic                  load,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int               PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic             AN_LOW    = (AN_ACTIVE_LOW != 0);

    // Scan position
    logic [PRE_W-1:0] prescaler;
    logic [IDX_W-1:0] scan_idx;
    logic             tick;
    logic             wrap;

    // Data currently being displayed
    logic [4*N_DIGITS-1:0] data_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [N_DIGITS-1:0]   blank_q;

    // Data waiting for the next frame boundary
    logic [4*N_DIGITS-1:0] pend_data;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic                  pending;

    // Per-digit darkening and the selected digit's view
    logic [N_DIGITS-1:0]   lzs_dark;
    logic [3:0]            sel_nibble;
    logic [6:0]            sel_glyph;
    logic                  sel_dark;
    logic                  sel_dp;
    logic                  in_blank;
    logic [MAX_DIGITS-1:0] an_full;
    logic                  unused_an_hi;

    assign tick = (prescaler == PRE_LAST);
    assign wrap = tick && (scan_idx == IDX_LAST);

    // Prescaler sets slot length; the digit pointer advances once per slot
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (tick) begin
            prescaler <= '0;
            scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Capture new display data, either immediately or held until the frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pending    <= 1'b0;
        end else if (FRAME_SYNC == 0) begin
            if (load) begin
                data_q  <= data_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
            end
        end else if (wrap) begin
            if (load) begin
                data_q  <= data_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
            end else if (pending) begin
                data_q  <= pend_data;
                dp_q    <= pend_dp;
                blank_q <= pend_blank;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pending    <= 1'b1;
        end
    end

    // Walk down from the most significant digit, darkening zeros until a
    // significant digit (non-zero, blanked, or carrying a decimal point) appears
    always_comb begin
        logic still_leading;
        lzs_dark      = '0;
        still_leading = lzs_en;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (still_leading && (data_q[4*k +: 4] == 4'h0) && !blank_q[k] && !dp_q[k]) begin
                lzs_dark[k] = 1'b1;
            end else begin
                still_leading = 1'b0;
            end
        end
    end

    assign sel_nibble = data_q[{scan_idx, 2'b00} +: 4];
    assign sel_dark   = blank_q[scan_idx] | lzs_dark[scan_idx];
    assign sel_dp     = dp_q[scan_idx];
    assign in_blank   = (prescaler < BLANK_END);

    sseg_hex_glyph u_glyph (
        .nibble (sel_nibble),
        .glyph  (sel_glyph)
    );

    assign an_full = anode_vector(3'(scan_idx), !in_blank, AN_LOW);

    // Anode lines above N_DIGITS do not exist on this display
    assign unused_an_hi = ^an_full;

    // Register all pins so they change cleanly one cycle behind the scan counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sseg       <= SEG_OFF;
            dp         <= 1'b1;
            an         <= {N_DIGITS{AN_LOW}};
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            digit_idx  <= scan_idx;
            frame_done <= wrap;
            an         <= an_full[N_DIGITS-1:0];
            if (in_blank || sel_dark) begin
                sseg <= SEG_OFF;
                dp   <= 1'b1;
            end else begin
                sseg <= sel_glyph;
                dp   <= ~sel_dp;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver. Two instances share one stimulus
// stream: one commits loads immediately, the other at the frame wrap.
module tb_sseg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BLK = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lzs_en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;

    logic [6:0] sseg0, sseg1;
    logic       dp0, dp1;
    logic [3:0] an0, an1;
    logic [1:0] idx0, idx1;
    logic       fd0, fd1;

    sseg_scan_driver #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLK),
        .AN_ACTIVE_LOW(1), .FRAME_SYNC(0)
    ) dut_fs0 (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lzs_en(lzs_en), .load(load),
        .sseg(sseg0), .dp(dp0), .an(an0), .digit_idx(idx0), .frame_done(fd0)
    );

    sseg_scan_driver #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLK),
        .AN_ACTIVE_LOW(1), .FRAME_SYNC(1)
    ) dut_fs1 (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lzs_en(lzs_en), .load(load),
        .sseg(sseg1), .dp(dp1), .an(an1), .digit_idx(idx1), .frame_done(fd1)
    );

    logic [6:0] glyph_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: scan position is derived from elapsed cycles since reset
    int          t = 0;
    logic [15:0] c_data  [2];
    logic [3:0]  c_dp    [2];
    logic [3:0]  c_blank [2];
    logic [15:0] p_data;
    logic [3:0]  p_dp;
    logic [3:0]  p_blank;
    bit          p_valid;
    int          last_idx;
    int          last_pre;
    bit          last_rst;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, actual, expected, t);
        end
    endtask

    // Digits above the most significant "significant" digit are dark under LZS
    function automatic logic [3:0] dark_mask(input logic [15:0] d, input logic [3:0] dpv,
                                             input logic [3:0] bl, input logic lz);
        int         msd;
        logic [3:0] m;
        msd = 0;
        for (int k = 0; k < N; k++) begin
            if (d[4*k +: 4] != 4'h0 || dpv[k] || bl[k]) msd = k;
        end
        m = bl;
        if (lz) begin
            for (int k = msd + 1; k < N; k++) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic setInputs(input logic r, input logic ld, input logic [15:0] d,
                             input logic [3:0] dpv, input logic [3:0] bl, input logic lz);
        rst      = r;
        load     = ld;
        data_in  = d;
        dp_in    = dpv;
        blank_in = bl;
        lzs_en   = lz;
    endtask

    task automatic step();
        logic [6:0] e_sseg [2];
        logic       e_dp   [2];
        logic [3:0] e_an   [2];
        logic [3:0] m;
        int         pre;
        int         idx;
        bit         wrap_now;
        pre      = t % DIV;
        idx      = (t / DIV) % N;
        wrap_now = (pre == DIV - 1) && (idx == N - 1);
        for (int i = 0; i < 2; i++) begin
            if (rst || pre < BLK) begin
                e_sseg[i] = 7'h7F;
                e_dp[i]   = 1'b1;
                e_an[i]   = 4'hF;
            end else begin
                m       = dark_mask(c_data[i], c_dp[i], c_blank[i], lzs_en);
                e_an[i] = ~(4'b0001 << idx);
                if (m[idx]) begin
                    e_sseg[i] = 7'h7F;
                    e_dp[i]   = 1'b1;
                end else begin
                    e_sseg[i] = glyph_ref[c_data[i][4*idx +: 4]];
                    e_dp[i]   = ~c_dp[i][idx];
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("sseg_fs0", sseg0, e_sseg[0]);
        checkOutput("dp_fs0",   dp0,   e_dp[0]);
        checkOutput("an_fs0",   an0,   e_an[0]);
        checkOutput("idx_fs0",  idx0,  rst ? 0 : idx);
        checkOutput("fd_fs0",   fd0,   rst ? 0 : wrap_now);
        checkOutput("sseg_fs1", sseg1, e_sseg[1]);
        checkOutput("dp_fs1",   dp1,   e_dp[1]);
        checkOutput("an_fs1",   an1,   e_an[1]);
        checkOutput("idx_fs1",  idx1,  rst ? 0 : idx);
        checkOutput("fd_fs1",   fd1,   rst ? 0 : wrap_now);
        last_idx = idx;
        last_pre = pre;
        last_rst = rst;
        if (rst) begin
            t = 0;
            for (int i = 0; i < 2; i++) begin
                c_data[i] = '0; c_dp[i] = '0; c_blank[i] = '0;
            end
            p_data = '0; p_dp = '0; p_blank = '0; p_valid = 1'b0;
        end else begin
            t++;
            if (load) begin
                c_data[0] = data_in; c_dp[0] = dp_in; c_blank[0] = blank_in;
            end
            if (wrap_now) begin
                if (load) begin
                    c_data[1] = data_in; c_dp[1] = dp_in; c_blank[1] = blank_in;
                end else if (p_valid) begin
                    c_data[1] = p_data; c_dp[1] = p_dp; c_blank[1] = p_blank;
                end
                p_valid = 1'b0;
            end else if (load) begin
                p_data = data_in; p_dp = dp_in; p_blank = blank_in; p_valid = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                                 input logic [3:0] dpv, input logic [3:0] bl, input logic lz);
        setInputs(r, ld, d, dpv, bl, lz);
        step();
    endtask

    // Advance until the outputs just shown are the lit part of digit k's slot
    task automatic runTo(input int k);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(last_pre >= BLK && last_idx == k && !last_rst) && n < 200);
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL runTo_timeout: digit %0d not reached, required within 200 cycles", k);
        end
    endtask

    // Advance until the next edge is the frame wrap tick
    task automatic runToWrap();
        int n;
        n = 0;
        while (!((t % DIV) == DIV - 1 && ((t / DIV) % N) == N - 1) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wrap_timeout: wrap not reached, required within 200 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          pulses;
        logic [15:0] rd;
        for (int i = 0; i < 2; i++) begin
            c_data[i] = '0; c_dp[i] = '0; c_blank[i] = '0;
        end
        p_data = '0; p_dp = '0; p_blank = '0; p_valid = 1'b0;

        // Reset held for three cycles
        repeat (3) applyStimulus(1, 0, 16'h0, 4'h0, 4'h0, 0);
        checkOutput("rst_sseg", sseg0, 7'h7F);
        checkOutput("rst_dp",   dp0,   1);
        checkOutput("rst_an",   an0,   4'b1111);
        checkOutput("rst_idx",  idx0,  0);
        checkOutput("rst_fd",   fd0,   0);
        checkOutput("rst_an1",  an1,   4'b1111);

        // Scan order with immediate commit
        applyStimulus(0, 1, 16'h12AF, 4'h0, 4'h0, 0);
        setInputs(0, 0, 16'h12AF, 4'h0, 4'h0, 0);
        runTo(0);
        checkOutput("scan0_an", an0, 4'b1110);  checkOutput("scan0_seg", sseg0, 7'b0111000);
        runTo(1);
        checkOutput("scan1_an", an0, 4'b1101);  checkOutput("scan1_seg", sseg0, 7'b0001000);
        runTo(2);
        checkOutput("scan2_an", an0, 4'b1011);  checkOutput("scan2_seg", sseg0, 7'b0010010);
        runTo(3);
        checkOutput("scan3_an", an0, 4'b0111);  checkOutput("scan3_seg", sseg0, 7'b1001111);
        pulses = 0;
        repeat (32) begin
            step();
            pulses += int'(fd0);
        end
        checkOutput("fd_period", pulses, 2);

        // Leading-zero suppression
        applyStimulus(0, 1, 16'h0070, 4'h0, 4'h0, 1);
        setInputs(0, 0, 16'h0070, 4'h0, 4'h0, 1);
        repeat (40) step();
        runTo(3);
        checkOutput("lzs_d3", sseg0, 7'h7F);  checkOutput("lzs_d3_an", an0, 4'b0111);
        checkOutput("lzs_d3_fs1", sseg1, 7'h7F);
        runTo(2);
        checkOutput("lzs_d2", sseg0, 7'h7F);
        runTo(1);
        checkOutput("lzs_d1", sseg0, 7'b0001111);
        runTo(0);
        checkOutput("lzs_d0", sseg0, 7'b0000001);
        applyStimulus(0, 1, 16'h0070, 4'b0100, 4'h0, 1);
        setInputs(0, 0, 16'h0070, 4'b0100, 4'h0, 1);
        repeat (40) step();
        runTo(2);
        checkOutput("lzs_dp_seg", sseg0, 7'b0000001);  checkOutput("lzs_dp_dp", dp0, 0);
        runTo(3);
        checkOutput("lzs_dp_d3", sseg0, 7'h7F);

        // Frame-synchronous update: last load before the wrap wins
        setInputs(0, 0, 16'h0070, 4'b0100, 4'h0, 0);
        runTo(0);
        runTo(1);
        applyStimulus(0, 1, 16'h1111, 4'h0, 4'h0, 0);
        setInputs(0, 0, 16'h1111, 4'h0, 4'h0, 0);
        runTo(2);
        applyStimulus(0, 1, 16'h2222, 4'h0, 4'h0, 0);
        setInputs(0, 0, 16'h2222, 4'h0, 4'h0, 0);
        runTo(3);
        checkOutput("fsync_hold", sseg1, 7'b0000001);
        runTo(0);
        checkOutput("fsync_new0", sseg1, 7'b0010010);  checkOutput("fsync_new0_dp", dp1, 1);
        runTo(3);
        checkOutput("fsync_new3", sseg1, 7'b0010010);

        // Load coincident with the wrap tick commits directly
        runToWrap();
        applyStimulus(0, 1, 16'h3333, 4'h0, 4'h0, 0);
        setInputs(0, 0, 16'h3333, 4'h0, 4'h0, 0);
        runTo(0);
        checkOutput("wrapload_d0", sseg1, 7'b0000110);
        checkOutput("wrapload_pending", dut_fs1.pending, 0);

        // Per-digit blank, then reset in the middle of a scan
        applyStimulus(0, 1, 16'h3333, 4'h0, 4'b0010, 0);
        setInputs(0, 0, 16'h3333, 4'h0, 4'b0010, 0);
        repeat (20) step();
        runTo(1);
        checkOutput("blank_seg", sseg0, 7'h7F);  checkOutput("blank_dp", dp0, 1);
        checkOutput("blank_an", an0, 4'b1101);
        runTo(2);
        applyStimulus(1, 0, 16'h3333, 4'h0, 4'b0010, 0);
        checkOutput("midrst_sseg", sseg0, 7'h7F);  checkOutput("midrst_an", an0, 4'b1111);
        checkOutput("midrst_idx", idx0, 0);        checkOutput("midrst_fd", fd0, 0);
        setInputs(0, 0, 16'h3333, 4'h0, 4'b0010, 0);
        runTo(0);
        checkOutput("postrst_fs0", sseg0, 7'b0000001);
        checkOutput("postrst_fs1", sseg1, 7'b0000001);

        // Randomised traffic against the model
        repeat (1500) begin
            rd = 16'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 0) rd[4*k +: 4] = 4'h0;
            end
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), rd,
                          4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                          4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
